// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic types and sizing helpers
// Contents:
//   sub_state_t   - control states of the bit-serial subtractor
//   cnt_width()   - bit-counter width for a given operand width
//   DEFAULT_CNT_W - counter width at the default 8-bit operand width
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Counter only needs to index bits 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell
// Ports:
//   a, b     - minuend and subtrahend bits
//   bor_in   - borrow from the lower bit
//   diff_out - difference bit
//   bor_out  - borrow into the next bit
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bor_in,
    output logic diff_out,
    output logic bor_out
);

    assign diff_out = a ^ b ^ bor_in;
    assign bor_out  = (~a & b) | (~(a ^ b) & bor_in);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial ripple-borrow subtractor
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (a, b, b_in)
//   a, b, b_in          - minuend, subtrahend, borrow-in
//   out_valid, out_ready- result handshake
//   diff, b_out, ovf    - a-b-b_in mod 2^WIDTH, final borrow, signed overflow
//   busy                - operation in progress
module serial_ripple_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    sub_state_t       r_state;
    sub_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bor;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_b_out;
    logic             r_ovf;
    logic             r_out_valid;
    logic             w_d;
    logic             w_bor;
    logic             w_last;

    // Operand shift registers move right, so bit 0 always feeds the cell.
    full_subtractor u_cell (
        .a        (r_a[0]),
        .b        (r_b[0]),
        .bor_in   (r_bor),
        .diff_out (w_d),
        .bor_out  (w_bor)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_bor       <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_b_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_bor   <= b_in;
                        r_cnt   <= '0;
                        r_diff  <= '0;
                        // MSBs are shifted out before the end, keep them for ovf.
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_bor  <= w_bor;
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_b_out <= w_bor;
                        // w_d is the final diff MSB on this edge.
                        r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = !rst && (r_state == S_IDLE);
    assign busy      = !rst && (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign b_out     = r_b_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - self-checking bench for serial_ripple_subtractor
module tb_serial_ripple_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int prev_acc = -1;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction, wrapped to W bits.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int r;
        r  = int'(x) - int'(y) - int'(bi);
        d  = r[W-1:0];
        bo = (r < 0);
        ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        int k = 0;
        a = ia;
        b = ib;
        b_in = ibin;
        in_valid = 1'b1;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        chk("accept_timeout", 32'(k < 40), 32'(1));
        tick();
        if (prev_acc >= 0) chk("accept_spacing", 32'((cyc - prev_acc) >= 10), 32'(1));
        prev_acc = cyc;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        b_in = 1'($urandom);
        chk("busy_shift", 32'(busy), 32'(1));
        chk("in_ready_shift", 32'(in_ready), 32'(0));
    endtask

    task automatic collect(input logic [W-1:0] ed, input logic eb, input logic eo,
                           input int stall, input int exp_lat);
        int k = 0;
        while (!out_valid && k < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("latency", 32'(k), 32'(exp_lat));
        chk("diff", 32'(diff), 32'(ed));
        chk("b_out", 32'(b_out), 32'(eb));
        chk("ovf", 32'(ovf), 32'(eo));
        chk("in_ready_done", 32'(in_ready), 32'(0));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            tick();
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_diff", 32'(diff), 32'(ed));
            chk("stall_b_out", 32'(b_out), 32'(eb));
            chk("stall_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'(0));
        chk("release_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [W-1:0] md;
        logic         mb;
        logic         mo;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         bi;
        int           seen;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_b_out", 32'(b_out), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_diff", 32'(diff), 32'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Basic subtract
        issue(8'h5A, 8'h23, 1'b0);
        collect(8'h37, 1'b0, 1'b0, 0, 8);

        // Underflow and borrow-in
        issue(8'h00, 8'h01, 1'b0);
        collect(8'hFF, 1'b1, 1'b0, 0, 8);
        issue(8'h10, 8'h0F, 1'b1);
        collect(8'h00, 1'b0, 1'b0, 0, 8);

        // Signed overflow
        issue(8'h80, 8'h01, 1'b0);
        collect(8'h7F, 1'b0, 1'b1, 0, 8);
        issue(8'h7F, 8'hFF, 1'b0);
        collect(8'h80, 1'b1, 1'b1, 0, 8);

        // Ignored input during SHIFT, then backpressure in DONE
        issue(8'h5A, 8'h23, 1'b0);
        tick();
        tick();
        a = 8'hFF;
        b = 8'h00;
        b_in = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("ignored_in_ready", 32'(in_ready), 32'(0));
        tick();
        in_valid = 1'b0;
        collect(8'h37, 1'b0, 1'b0, 5, 4);

        // Reset while processing bit 4
        issue(8'h33, 8'h11, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_b_out", 32'(b_out), 32'(0));
        chk("mid_rst_ovf", 32'(ovf), 32'(0));
        rst = 1'b0;
        tick();
        chk("mid_rst_ready_after", 32'(in_ready), 32'(1));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("aborted_no_result", 32'(seen), 32'(0));
        issue(8'hFF, 8'hFF, 1'b0);
        collect(8'h00, 1'b0, 1'b0, 0, 8);

        // Randomized back-to-back against the reference model
        for (int n = 0; n < 1000; n++) begin
            x  = W'($urandom);
            y  = W'($urandom);
            bi = 1'($urandom);
            model(x, y, bi, md, mb, mo);
            issue(x, y, bi);
            collect(md, mb, mo, $urandom_range(0, 3), 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
